// File: rtl/symmetry_pattern_gen.sv
// Generates an 8-bit word with an exact number of broken mirror pairs.
// The low half-word comes from an internal LFSR. The high half-word is built
// one pair per cycle as the mirror of the low half, with the selected pairs inverted.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; latches k_eff = min(k, 4)
// LOAD   | low half from LFSR, build flip mask at rotation lfsr[5:4], step LFSR
// BUILD  | four cycles; pair p writes word[7-p] = word[p] ^ mask[p]
// DONE   | word offered on valid/ready; handshake returns to IDLE
module symmetry_pattern_gen #(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       start_i,
   input  logic [2:0] k_i,
   input  logic       ready_i,
   output logic [7:0] word_o,
   output logic [2:0] word_k_o,
   output logic       valid_o,
   output logic       busy_o,
   output logic [7:0] words_sent_o
);

   // An all-zero LFSR would lock up, so a zero seed is replaced by 8'h01.
   localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_BUILD,
      S_DONE
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] p_q, p_d;
   logic [7:0] word_q, word_d;
   logic [3:0] mask_q, mask_d;
   logic [2:0] k_q, k_d;
   logic [7:0] lfsr_q, lfsr_d;
   logic [7:0] cnt_q, cnt_d;

   logic [3:0] base;
   logic [7:0] mask_dbl;
   logic       fb;

   // State and datapath registers, synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         p_q     <= 2'd0;
         word_q  <= 8'h00;
         mask_q  <= 4'h0;
         k_q     <= 3'd0;
         lfsr_q  <= SEED_EFF;
         cnt_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         word_q  <= word_d;
         mask_q  <= mask_d;
         k_q     <= k_d;
         lfsr_q  <= lfsr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Flip mask: k_eff consecutive ones rotated to start at pair lfsr[5:4].
   always_comb begin
      case (k_q)
         3'd0:    base = 4'b0000;
         3'd1:    base = 4'b0001;
         3'd2:    base = 4'b0011;
         3'd3:    base = 4'b0111;
         default: base = 4'b1111;
      endcase
      mask_dbl = {base, base} << lfsr_q[5:4];
      fb       = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      word_d  = word_q;
      mask_d  = mask_q;
      k_d     = k_q;
      lfsr_d  = lfsr_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               k_d     = (k_i > 3'd4) ? 3'd4 : k_i;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            word_d  = {4'h0, lfsr_q[3:0]};
            mask_d  = mask_dbl[7:4];
            lfsr_d  = {lfsr_q[6:0], fb};
            p_d     = 2'd0;
            state_d = S_BUILD;
         end
         S_BUILD: begin
            // Index 7-p is {1, ~p} for p in 0..3.
            word_d[{1'b1, ~p_q}] = word_q[p_q] ^ mask_q[p_q];
            if (p_q == 2'd3) begin
               state_d = S_DONE;
            end else begin
               p_d = p_q + 2'd1;
            end
         end
         S_DONE: begin
            if (ready_i) begin
               cnt_d   = cnt_q + 8'd1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign word_o       = word_q;
   assign word_k_o     = k_q;
   assign valid_o      = (state_q == S_DONE);
   assign busy_o       = (state_q != S_IDLE);
   assign words_sent_o = cnt_q;

endmodule

// File: tb/tb_symmetry_pattern_gen.sv
// Directed bench for symmetry_pattern_gen with hand-computed expected words.
module tb_symmetry_pattern_gen;

   logic       clk_i = 1'b0;
   logic       rst_n_i = 1'b0;
   logic       start_i = 1'b0;
   logic [2:0] k_i = 3'd0;
   logic       ready_i = 1'b0;
   logic [7:0] word_o;
   logic [2:0] word_k_o;
   logic       valid_o;
   logic       busy_o;
   logic [7:0] words_sent_o;

   int n_checks = 0;
   int n_pass   = 0;

   symmetry_pattern_gen #(.SEED(8'hA5)) dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .start_i      (start_i),
      .k_i          (k_i),
      .ready_i      (ready_i),
      .word_o       (word_o),
      .word_k_o     (word_k_o),
      .valid_o      (valid_o),
      .busy_o       (busy_o),
      .words_sent_o (words_sent_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic int mirror_mismatches(input logic [7:0] w);
      int n = 0;
      for (int i = 0; i < 4; i++) if (w[7-i] != w[i]) n++;
      return n;
   endfunction

   task automatic apply_reset();
      @(negedge clk_i);
      rst_n_i = 1'b0;
      start_i = 1'b0;
      ready_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      rst_n_i = 1'b1;
   endtask

   // Drives a one-cycle start from a negedge and returns the number of edges
   // from the start-sampling edge until valid is seen (99 on timeout).
   task automatic issue(input logic [2:0] kk, output int lat);
      int edges;
      start_i = 1'b1;
      k_i     = kk;
      @(posedge clk_i);
      edges = 1;
      #1 start_i = 1'b0;
      lat = 99;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk_i);
         if (valid_o) begin
            lat = edges;
            break;
         end
         @(posedge clk_i);
         edges++;
      end
   endtask

   task automatic transfer();
      ready_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      ready_i = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk_i);
      rst_n_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      n_checks++; if (word_o !== 8'h00) $display("FAIL reset_word: got %h want 00", word_o); else n_pass++;
      n_checks++; if (word_k_o !== 3'd0) $display("FAIL reset_word_k: got %0d want 0", word_k_o); else n_pass++;
      n_checks++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o); else n_pass++;
      n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else n_pass++;
      n_checks++; if (words_sent_o !== 8'h00) $display("FAIL reset_words_sent: got %0d want 0", words_sent_o); else n_pass++;
      rst_n_i = 1'b1;
   endtask

   task automatic test_k0_palindrome();
      int lat;
      issue(3'd0, lat);
      n_checks++; if (lat !== 6) $display("FAIL k0_latency: got %0d want 6", lat); else n_pass++;
      n_checks++; if (word_o !== 8'hA5) $display("FAIL k0_word: got %h want a5", word_o); else n_pass++;
      n_checks++; if (word_k_o !== 3'd0) $display("FAIL k0_word_k: got %0d want 0", word_k_o); else n_pass++;
      n_checks++; if (busy_o !== 1'b1) $display("FAIL k0_busy_done: got %b want 1", busy_o); else n_pass++;
      transfer();
      n_checks++; if (valid_o !== 1'b0) $display("FAIL k0_valid_after: got %b want 0", valid_o); else n_pass++;
      n_checks++; if (busy_o !== 1'b0) $display("FAIL k0_busy_after: got %b want 0", busy_o); else n_pass++;
      n_checks++; if (words_sent_o !== 8'd1) $display("FAIL k0_words_sent: got %0d want 1", words_sent_o); else n_pass++;
   endtask

   task automatic test_k1();
      int lat;
      apply_reset();
      issue(3'd1, lat);
      n_checks++; if (word_o !== 8'h85) $display("FAIL k1_word: got %h want 85", word_o); else n_pass++;
      n_checks++; if (word_k_o !== 3'd1) $display("FAIL k1_word_k: got %0d want 1", word_k_o); else n_pass++;
      n_checks++; if (mirror_mismatches(word_o) !== 1) $display("FAIL k1_mismatches: got %0d want 1", mirror_mismatches(word_o)); else n_pass++;
      transfer();
   endtask

   task automatic test_k_saturate();
      int lat;
      apply_reset();
      issue(3'd7, lat);
      n_checks++; if (word_o !== 8'h55) $display("FAIL k7_word: got %h want 55", word_o); else n_pass++;
      n_checks++; if (word_k_o !== 3'd4) $display("FAIL k7_word_k: got %0d want 4", word_k_o); else n_pass++;
      n_checks++; if (mirror_mismatches(word_o) !== 4) $display("FAIL k7_mismatches: got %0d want 4", mirror_mismatches(word_o)); else n_pass++;
      transfer();
   endtask

   task automatic test_back_to_back();
      int lat;
      apply_reset();
      issue(3'd0, lat);
      n_checks++; if (word_o !== 8'hA5) $display("FAIL b2b_first: got %h want a5", word_o); else n_pass++;
      transfer();
      issue(3'd0, lat);
      n_checks++; if (lat !== 6) $display("FAIL b2b_latency: got %0d want 6", lat); else n_pass++;
      n_checks++; if (word_o !== 8'h5A) $display("FAIL b2b_second: got %h want 5a", word_o); else n_pass++;
      transfer();
      n_checks++; if (words_sent_o !== 8'd2) $display("FAIL b2b_words_sent: got %0d want 2", words_sent_o); else n_pass++;
   endtask

   // Continues from the back-to-back state: LFSR is 95, so k=2 gives c5.
   task automatic test_stall();
      int lat;
      int unstable = 0;
      issue(3'd2, lat);
      n_checks++; if (word_o !== 8'hC5) $display("FAIL stall_word: got %h want c5", word_o); else n_pass++;
      n_checks++; if (word_k_o !== 3'd2) $display("FAIL stall_word_k: got %0d want 2", word_k_o); else n_pass++;
      for (int c = 0; c < 10; c++) begin
         start_i = (c == 3 || c == 4);
         k_i     = 3'd4;
         @(posedge clk_i);
         @(negedge clk_i);
         if (valid_o !== 1'b1 || word_o !== 8'hC5 || word_k_o !== 3'd2) unstable++;
      end
      start_i = 1'b0;
      n_checks++; if (unstable !== 0) $display("FAIL stall_stable: got %0d unstable cycles want 0", unstable); else n_pass++;
      transfer();
      n_checks++; if (words_sent_o !== 8'd3) $display("FAIL stall_words_sent: got %0d want 3", words_sent_o); else n_pass++;
      repeat (3) @(negedge clk_i);
      n_checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0) $display("FAIL stall_no_queue: got busy %b valid %b want 0 0", busy_o, valid_o); else n_pass++;
   endtask

   // LFSR now 2A: low half a, rotation 2, k=3 flips pairs 2,3,0.
   task automatic test_k3();
      int lat;
      issue(3'd3, lat);
      n_checks++; if (word_o !== 8'hEA) $display("FAIL k3_word: got %h want ea", word_o); else n_pass++;
      n_checks++; if (mirror_mismatches(word_o) !== 3) $display("FAIL k3_mismatches: got %0d want 3", mirror_mismatches(word_o)); else n_pass++;
      transfer();
   endtask

   task automatic test_reset_mid_and_wrap();
      int lat;
      start_i = 1'b1;
      k_i     = 3'd1;
      @(posedge clk_i);
      #1 start_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      rst_n_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      n_checks++; if (valid_o !== 1'b0) $display("FAIL mid_reset_valid: got %b want 0", valid_o); else n_pass++;
      n_checks++; if (busy_o !== 1'b0) $display("FAIL mid_reset_busy: got %b want 0", busy_o); else n_pass++;
      n_checks++; if (words_sent_o !== 8'd0) $display("FAIL mid_reset_words_sent: got %0d want 0", words_sent_o); else n_pass++;
      rst_n_i = 1'b1;
      issue(3'd0, lat);
      n_checks++; if (word_o !== 8'hA5) $display("FAIL mid_reset_lfsr: got %h want a5", word_o); else n_pass++;
      transfer();
      for (int i = 1; i < 255; i++) begin
         issue(3'd0, lat);
         if (lat == 99) break;
         transfer();
      end
      n_checks++; if (words_sent_o !== 8'd255) $display("FAIL wrap_255: got %0d want 255", words_sent_o); else n_pass++;
      issue(3'd0, lat);
      n_checks++; if (lat !== 6) $display("FAIL wrap_latency: got %0d want 6", lat); else n_pass++;
      transfer();
      n_checks++; if (words_sent_o !== 8'd0) $display("FAIL wrap_0: got %0d want 0", words_sent_o); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_k0_palindrome();
      test_k1();
      test_k_saturate();
      test_back_to_back();
      test_stall();
      test_k3();
      test_reset_mid_and_wrap();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
